// File: rtl/byte_memory_ctrl_if.sv
// Request/response bundle between the MEM stage and the byte memory.
// The master issues loads/stores; the slave answers with a one-cycle pulse.
interface byte_memory_ctrl_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 6
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [1:0]               req_size;
    logic                     req_unsigned;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    write_data;
    logic                     resp_valid;
    logic [DATA_WIDTH-1:0]    resp_data;
    logic                     resp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, address, write_data,
        input  req_ready, resp_valid, resp_data, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, address, write_data,
        output req_ready, resp_valid, resp_data, resp_error
    );
endinterface

// File: rtl/byte_memory_ctrl.sv
// Little-endian byte memory with B/H/W/D loads and stores, sign/zero
// extension, misalignment errors and a clear sweep after reset.
module byte_memory_ctrl #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic              clk,
    input  logic              reset,
    byte_memory_ctrl_if.slave bus,
    output logic              init_done
);
    localparam int BYTES       = DATA_WIDTH / 8;
    localparam int DEPTH       = 2 ** ADDRESS_WIDTH;
    localparam int INIT_CYCLES = DEPTH / BYTES;
    localparam int CW          = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int BO          = $clog2(BYTES);

    typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

    state_t                   state;
    logic [CW-1:0]            count;
    logic [7:0]               mem [DEPTH];
    logic [7:0]               rd_byte [8];
    logic [ADDRESS_WIDTH-1:0] clr_base;
    logic [DATA_WIDTH-1:0]    load_val;
    logic                     accept;
    logic                     misaligned;
    logic                     err;
    logic                     sign;
    int                       n;

    assign accept   = (state == IDLE) && bus.req_valid && bus.req_ready;
    assign clr_base = ADDRESS_WIDTH'({count, {BO{1'b0}}});

    always_comb begin
        n          = 32'd1 << bus.req_size;
        misaligned = (bus.address & ADDRESS_WIDTH'(n - 1)) != '0;
        err        = (n > BYTES) || misaligned;
        for (int i = 0; i < 8; i++) begin
            rd_byte[i] = mem[bus.address + ADDRESS_WIDTH'(i)];
        end
        sign = 1'b0;
        unique case (bus.req_size)
            2'd0: sign = rd_byte[0][7];
            2'd1: sign = rd_byte[1][7];
            2'd2: sign = rd_byte[3][7];
            2'd3: sign = rd_byte[7][7];
        endcase
        // bytes beyond the access length carry the extension fill
        load_val = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < n)
                load_val[8*i +: 8] = rd_byte[i];
            else
                load_val[8*i +: 8] = {8{sign && !bus.req_unsigned}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= INIT;
            count          <= '0;
            init_done      <= 1'b0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_error <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    count <= count + 1'b1;
                    if (count == CW'(INIT_CYCLES - 1)) begin
                        state         <= IDLE;
                        init_done     <= 1'b1;
                        bus.req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        state          <= RESP;
                        bus.req_ready  <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_error <= err;
                        bus.resp_data  <= (err || bus.req_write) ? '0 : load_val;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                end
                default: state <= INIT;
            endcase
        end
    end

    // a store coinciding with reset is dropped; the sweep owns memory in INIT
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                for (int i = 0; i < BYTES; i++)
                    mem[clr_base + ADDRESS_WIDTH'(i)] <= 8'h00;
            end else if (accept && bus.req_write && !err) begin
                for (int i = 0; i < BYTES; i++)
                    if (i < n)
                        mem[bus.address + ADDRESS_WIDTH'(i)] <= bus.write_data[8*i +: 8];
            end
        end
    end
endmodule
